// File: rtl/uart_tx_fifo_if.sv
// Core-side bus of the buffered UART transmitter: write port, bit-period
// divisor and FIFO/transmitter status.
interface uart_tx_fifo_if #(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
);
    logic [DIV_W-1:0]   divisor;
    logic [7:0]         din;
    logic               wr;
    logic               full;
    logic               empty;
    logic [FIFO_AW:0]   count;
    logic               ovf;
    logic               busy;

    modport master (
        output divisor, din, wr,
        input  full, empty, count, ovf, busy
    );

    modport slave (
        input  divisor, din, wr,
        output full, empty, count, ovf, busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: 2^FIFO_AW-byte FIFO feeding an LSB-first serialiser.
// Optional UART_TX_CTS_EN adds an active-low clear-to-send input gating frame starts.
module uart_tx_fifo #(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
) (
    input  logic            clk_sys,
    input  logic            reset,
`ifdef UART_TX_CTS_EN
    input  logic            cts_n,
`endif
    uart_tx_fifo_if.slave   bus,
    output logic            tx
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               ovf_q;

    state_e             state_q;
    state_e             state_d;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic [DIV_W-1:0]   timer_q;
    logic [DIV_W-1:0]   timer_d;
    logic [2:0]         bit_idx_q;
    logic [2:0]         bit_idx_d;
    logic [7:0]         shift_q;
    logic [7:0]         shift_d;
    logic               tx_q;
    logic               tx_d;

    logic               full_w;
    logic               empty_w;
    logic               wr_acc;
    logic               pop;
    logic               tx_ok;
    logic               start_ok;
    logic [DIV_W-1:0]   div_clamped;

`ifdef UART_TX_CTS_EN
    logic [1:0]         cts_sync_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cts_sync_q <= 2'b11;
        end else begin
            cts_sync_q <= {cts_sync_q[0], cts_n};
        end
    end

    assign tx_ok = ~cts_sync_q[1];
`else
    assign tx_ok = 1'b1;
`endif

    assign full_w      = (count_q == DEPTH_C);
    assign empty_w     = (count_q == '0);
    // A pop in the same cycle never frees a slot for a write to a full FIFO.
    assign wr_acc      = bus.wr & ~full_w;
    assign start_ok    = ~empty_w & tx_ok;
    assign div_clamped = (bus.divisor < DIV_W'(2)) ? DIV_W'(2) : bus.divisor;

    always_ff @(posedge clk_sys) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    always_comb begin
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (start_ok) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    shift_d = mem_q[rd_ptr_q];
                    div_d   = div_clamped;
                    timer_d = div_clamped - 1'b1;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    state_d   = S_DATA;
                    timer_d   = div_q - 1'b1;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = div_q - 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == '0) begin
                    // Chain straight into the next start bit so queued frames have no gap.
                    if (start_ok) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                        shift_d = mem_q[rd_ptr_q];
                        div_d   = div_clamped;
                        timer_d = div_clamped - 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            div_q     <= '0;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (bus.wr && full_w) begin
                ovf_q <= 1'b1;
            end
            count_q   <= count_d;
            state_q   <= state_d;
            div_q     <= div_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single-byte frames plus
// back-to-back, divisor change, overflow, reset and clear-to-send sequences.
module tb_uart_tx_fifo;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic tx;
`ifdef UART_TX_CTS_EN
    logic cts_n = 1'b0;
`endif

    uart_tx_fifo_if #(.FIFO_AW(4), .DIV_W(16)) bus ();

    uart_tx_fifo #(.FIFO_AW(4), .DIV_W(16)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
`ifdef UART_TX_CTS_EN
        .cts_n   (cts_n),
`endif
        .bus     (bus),
        .tx      (tx)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] div;
        logic [7:0]  data;
        logic [9:0]  frame;   // bit 0 = start bit, bit 9 = stop bit
        int          clks;
    } vec_t;

    vec_t vecs [5];
    logic tx_cap   [0:2047];
    logic busy_cap [0:2047];
    int   nvec  = 0;
    int   nfail = 0;
    int   p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic capture(input int n, input int chg_at, input logic [15:0] chg_val);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            tx_cap[i]   = tx;
            busy_cap[i] = bus.busy;
            bus.wr      = 1'b0;
            if (i == chg_at) bus.divisor = chg_val;
        end
    endtask

    task automatic check_bits(input logic [9:0] frame, input int div, input int off, input string tag);
        for (int k = 0; k < 10; k++) begin
            logic got;
            got = frame[k];
            for (int j = 0; j < div; j++) begin
                if (tx_cap[off + k*div + j] !== frame[k]) got = tx_cap[off + k*div + j];
            end
            chk($sformatf("%s bit%0d", tag, k), {31'd0, got}, {31'd0, frame[k]});
        end
    endtask

    function automatic int busy_len(input int n);
        int bl = 0;
        while (bl < n && busy_cap[bl] === 1'b1) bl++;
        return bl;
    endfunction

    initial begin
        logic [9:0] fr;
        int bad;
        int lat;

        vecs[0] = '{16'd4, 8'h55, 10'b1010101010, 40};
        vecs[1] = '{16'd0, 8'hA5, 10'b1101001010, 20};
        vecs[2] = '{16'd1, 8'h3C, 10'b1001111000, 20};
        vecs[3] = '{16'd7, 8'h81, 10'b1100000010, 70};
        vecs[4] = '{16'd3, 8'h00, 10'b1000000000, 30};

        bus.divisor = 16'd4;
        bus.din     = 8'h00;
        bus.wr      = 1'b0;
        reset       = 1'b1;
        repeat (3) step();
        chk("rst tx",    {31'd0, tx},        32'd1);
        chk("rst busy",  {31'd0, bus.busy},  32'd0);
        chk("rst empty", {31'd0, bus.empty}, 32'd1);
        chk("rst full",  {31'd0, bus.full},  32'd0);
        chk("rst count", {27'd0, bus.count}, 32'd0);
        chk("rst ovf",   {31'd0, bus.ovf},   32'd0);
        reset = 1'b0;
        repeat (3) step();

        for (int v = 0; v < 5; v++) begin
            bus.divisor = vecs[v].div;
            bus.din     = vecs[v].data;
            bus.wr      = 1'b1;
            step();
            bus.wr = 1'b0;
            chk($sformatf("v%0d wr count", v), {27'd0, bus.count}, 32'd1);
            chk($sformatf("v%0d wr empty", v), {31'd0, bus.empty}, 32'd0);
            chk($sformatf("v%0d wr tx", v),    {31'd0, tx},        32'd1);
            capture(vecs[v].clks + 1, -1, 16'd0);
            check_bits(vecs[v].frame, vecs[v].clks / 10, 0, $sformatf("v%0d", v));
            chk($sformatf("v%0d busy_len", v), busy_len(vecs[v].clks + 1), vecs[v].clks);
            chk($sformatf("v%0d idle tx", v),  {31'd0, tx_cap[vecs[v].clks]}, 32'd1);
            chk($sformatf("v%0d empty", v),    {31'd0, bus.empty}, 32'd1);
            $display("vector %0d: divisor=%0d byte=%02h frame_clocks=%0d", v, vecs[v].div, vecs[v].data, vecs[v].clks);
            repeat (2) step();
        end

        // Back-to-back frames
        bus.divisor = 16'd3;
        bus.din = 8'h00; bus.wr = 1'b1;
        step();
        bus.din = 8'hFF;
        capture(61, -1, 16'd0);
        check_bits(10'b1000000000, 3, 0,  "b2b0");
        check_bits(10'b1111111110, 3, 30, "b2b1");
        chk("b2b busy_len", busy_len(61), 60);
        $display("sequence b2b: 0x00,0xFF at divisor 3");
        repeat (2) step();

        // Divisor clamp and mid-frame change
        bus.divisor = 16'd0;
        bus.din = 8'hA5; bus.wr = 1'b1;
        step();
        bus.din = 8'h5A;
        capture(101, 5, 16'd8);
        check_bits(10'b1101001010, 2, 0,  "chg0");
        check_bits(10'b1010110100, 8, 20, "chg1");
        chk("chg busy_len", busy_len(101), 100);
        $display("sequence divisor change: 0xA5 at 2, 0x5A at 8");
        repeat (2) step();

        // Overflow: 18 writes, one dropped
        bus.divisor = 16'd100;
        p = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 17) begin
                chk("ovf pre full",  {31'd0, bus.full},  32'd1);
                chk("ovf pre ovf",   {31'd0, bus.ovf},   32'd0);
                chk("ovf pre count", {27'd0, bus.count}, 32'd16);
            end
            bus.din = 8'h10 + 8'(i);
            bus.wr  = 1'b1;
            step(); p++;
        end
        bus.wr = 1'b0;
        chk("ovf flag",  {31'd0, bus.ovf},   32'd1);
        chk("ovf full",  {31'd0, bus.full},  32'd1);
        chk("ovf count", {27'd0, bus.count}, 32'd16);
        for (int k = 0; k < 17; k++) begin
            for (int b = 0; b < 10; b++) begin
                while (p < 52 + 1000*k + 100*b) begin step(); p++; end
                fr[b] = tx;
            end
            chk($sformatf("ovf frame%0d", k), {22'd0, fr}, {22'd0, 1'b1, 8'h10 + 8'(k), 1'b0});
        end
        while (p < 17005) begin step(); p++; end
        chk("ovf end busy",  {31'd0, bus.busy},  32'd0);
        chk("ovf end empty", {31'd0, bus.empty}, 32'd1);
        chk("ovf sticky",    {31'd0, bus.ovf},   32'd1);
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            step();
            if (tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        chk("ovf no extra frame", bad, 0);
        $display("sequence overflow: 17 bytes sent, 1 dropped");

        // Reset mid-frame during data bit 3
        bus.divisor = 16'd10;
        p = 0;
        for (int i = 0; i < 3; i++) begin
            bus.din = 8'h00 + 8'(i * 17);
            bus.wr  = 1'b1;
            step(); p++;
        end
        bus.wr = 1'b0;
        while (p < 47) begin step(); p++; end
        chk("mid tx",    {31'd0, tx},        32'd0);
        chk("mid busy",  {31'd0, bus.busy},  32'd1);
        chk("mid count", {27'd0, bus.count}, 32'd2);
        reset = 1'b1;
        step();
        chk("mrst tx",    {31'd0, tx},        32'd1);
        chk("mrst count", {27'd0, bus.count}, 32'd0);
        chk("mrst busy",  {31'd0, bus.busy},  32'd0);
        chk("mrst empty", {31'd0, bus.empty}, 32'd1);
        chk("mrst ovf",   {31'd0, bus.ovf},   32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        chk("mrst quiet", bad, 0);
        $display("sequence reset mid-frame");

        // Reset and write in the same cycle
        reset = 1'b1; bus.din = 8'h77; bus.wr = 1'b1;
        step();
        reset = 1'b0; bus.wr = 1'b0;
        step();
        chk("rstwr count", {27'd0, bus.count}, 32'd0);
        chk("rstwr busy",  {31'd0, bus.busy},  32'd0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tx !== 1'b1) bad++;
        end
        chk("rstwr quiet", bad, 0);
        $display("sequence reset with write");

`ifdef UART_TX_CTS_EN
        cts_n = 1'b1;
        repeat (3) step();
        bus.divisor = 16'd2;
        bus.din = 8'h41; bus.wr = 1'b1;
        step();
        bus.wr = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        chk("cts held", bad, 0);
        cts_n = 1'b0;
        lat = 0;
        while (tx === 1'b1 && lat < 10) begin step(); lat++; end
        chk("cts latency ok", {31'd0, (lat >= 1 && lat <= 3)}, 32'd1);
        lat = 0;
        while (bus.busy === 1'b1 && lat < 100) begin step(); lat++; end
        chk("cts frame done", {31'd0, bus.busy}, 32'd0);
        $display("sequence clear-to-send");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter driving the board's `UART_TX` pin. It is the transmit counterpart of the core's serial receiver on `UART_RX`. The guest core (DVK terminal/serial port) pushes bytes into a small FIFO. The block serialises them LSB-first at a runtime-programmable bit period. It exposes full/empty/overflow status so the core's register logic can implement a transmit-ready flag.

## Interface
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW entries (16).
- `DIV_W`, default 16: width of the bit-period divisor.
- `clk_sys`  in  1  system clock. All logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `divisor`  in  DIV_W  clocks per bit. Values 0 and 1 are treated as 2.
- `din`  in  8  byte to transmit.
- `wr`  in  1  write strobe. One byte is pushed per cycle in which `wr`=1.
- `full`  out  1  FIFO holds 2^FIFO_AW entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  FIFO_AW+1  current FIFO occupancy.
- `ovf`  out  1  sticky flag: a write was attempted while `full`.
- `busy`  out  1  a frame is being shifted (state ≠ IDLE).
- `tx`  out  1  serial line output, idle high.

## Operation
- FIFO:
  - Synchronous-write/registered-read circular buffer.
  - A write is accepted iff `full`=0 at that edge. A pop in the same cycle does not free a slot for that write.
  - A write to a full FIFO is dropped and sets `ovf`=1. `ovf` stays set until `reset`.
  - Simultaneous accepted write and pop leave `count` unchanged.
  - Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `empty`=0, pop the head byte into the shift register, latch `divisor` (clamped to ≥2) into `div_q`, and go to START.
  - START: `tx`=0 for `div_q` clocks, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `div_q` clocks, then shift right. After bit index 7, go to STOP.
  - STOP: `tx`=1 for `div_q` clocks. Then return to IDLE. If the FIFO is non-empty at that point, the pop happens in the same cycle, so frames are back-to-back with no extra idle bit.
- Bit timer: a down-counter reloaded with `div_q`-1 at each bit boundary. A change to `divisor` mid-frame takes effect only at the next frame start.
- Frame length is exactly 10·`div_q` clocks.

## Timing
- Reset values: `tx`=1, `busy`=0, `empty`=1, `full`=0, `count`=0, `ovf`=0. FIFO pointers = 0, FSM = IDLE.
- Write latency: `wr` sampled at edge N (FIFO empty, FSM IDLE):
  - `count`=1 and `empty`=0 after edge N.
  - Pop and FSM→START at edge N+1.
  - `tx` falls after edge N+1. `tx` is registered, so there are no combinational paths to the pin.
- `count`/`full`/`empty` update on the edge following the accepted write or pop.
- `reset` mid-frame: after the next edge `tx`=1, FIFO is emptied, `ovf` is cleared and FSM is in IDLE. The partial frame is abandoned.
- `reset` and `wr` in the same cycle: reset wins and the byte is discarded.

## Configuration
- `UART_TX_CTS_EN`:
  - Defined: adds port `cts_n` (in, 1, active-low clear-to-send, double-registered internally). The IDLE→START transition additionally requires synchronised `cts_n`=0. Deasserting `cts_n` mid-frame does not interrupt the current frame; it only blocks the next one.
  - Undefined: no `cts_n` port. Transmission starts whenever the FIFO is non-empty.

## Test plan
- Single byte: `divisor`=4, write 0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 clocks (40 clocks total). `busy` high for exactly 40 clocks. `empty`=1 afterwards.
- Back-to-back: `divisor`=3, write 0x00 then 0xFF on consecutive cycles → two 30-clock frames with no idle gap. Second frame start bit begins the clock after the first stop bit ends.
- Overflow: `divisor`=100, write 18 bytes in 18 consecutive cycles → first byte popped at cycle 2, so 17 stored at most. 16 in FIFO + 1 in shifter. Exactly one write dropped; `ovf`=1, `full`=1. The dropped byte never appears on `tx`.
- Divisor clamp and change: `divisor`=0, send 0xA5 → 2-clock bits. Change `divisor` to 8 mid-frame → current frame keeps 2-clock bits; the next byte uses 8.
- Reset mid-frame: `divisor`=10, 3 bytes queued, assert `reset` during DATA bit 3 → `tx`=1, `count`=0, `busy`=0 after one edge. No further activity.
- With `UART_TX_CTS_EN`: `cts_n`=1, write 0x41 → `tx` stays 1 indefinitely. Drive `cts_n`=0 → start bit begins within 3 clocks (2 sync stages + FSM).
